eo_pair_packer: RTL and testbench

- Downstream consumer of the even/odd interleaving stage; drives that stage's read enable and captures its registered byte output.
- Issues exactly one read per byte, in the order even, odd, even, odd. Each even/odd pair is packed into a 16-bit word and offered on a valid/ready interface.
- Checks the LSB class of every captured byte: even bytes must have LSB 0, odd bytes LSB 1.
- Maintains a pair counter and an error counter.

---
 rtl/eo_pkg.sv | 24 ++
 rtl/eo_sat_counter.sv | 36 +++
 rtl/eo_pair_packer.sv | 142 ++++++++++++++
 tb/tb_eo_pair_packer.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eo_pkg.sv
// Shared types for the even/odd pair packer.
//   state_e : packer FSM states
//   pair_t  : packed output word, odd byte in the upper half
//   BYTE_W  : upstream byte width
//   PAIR_W  : packed pair width
package eo_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned PAIR_W = 16;

    typedef enum logic [2:0] {
        S_REQ_E,
        S_CAP_E,
        S_REQ_O,
        S_CAP_O,
        S_HOLD
    } state_e;

    typedef struct packed {
        logic [BYTE_W-1:0] odd;
        logic [BYTE_W-1:0] even;
    } pair_t;

endpackage

// File: rtl/eo_sat_counter.sv
// Up-counter with an enable and a saturate-versus-wrap select.
//   clk   : clock
//   reset : asynchronous active-low reset, clears the count
//   en    : count one on this clock edge
//   sat   : 1 = hold at all-ones, 0 = wrap to zero
//   count : current count
module eo_sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         sat,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (en && !(sat && (&count_q))) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/eo_pair_packer.sv
// Reads bytes from the even/odd interleaving stage one at a time (even, odd,
// even, odd ...), packs each pair into {odd, even} and offers it on a
// valid/ready interface. Every byte's LSB is checked against its class.
//   clk        : clock
//   reset      : asynchronous active-low reset
//   src_avail  : upstream has a byte of the class wanted next
//   src_r_en   : one-cycle read pulse to upstream
//   src_d_in   : upstream registered byte, valid the cycle after src_r_en
//   pair_valid : packed pair offered
//   pair_ready : downstream accepts the pair
//   pair_data  : {odd_byte, even_byte}
//   pair_err   : offered pair has a class mismatch
//   pair_count : pairs accepted downstream (wraps)
//   err_count  : mismatched pairs seen (saturates)
// Build option: define EO_PAIR_DROP_ERR_EN to drop mismatched pairs instead of
// presenting them; pair_err is then always 0.
module eo_pair_packer
    import eo_pkg::*;
#(
    parameter int unsigned CNT_W = 16,
    parameter int unsigned ERR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              src_avail,
    output logic              src_r_en,
    input  logic [BYTE_W-1:0] src_d_in,
    output logic              pair_valid,
    input  logic              pair_ready,
    output logic [PAIR_W-1:0] pair_data,
    output logic              pair_err,
    output logic [CNT_W-1:0]  pair_count,
    output logic [ERR_W-1:0]  err_count
);

    state_e            state_q, state_d;
    logic [BYTE_W-1:0] even_q, even_d;
    logic              e_bad_q, e_bad_d;
    pair_t             pair_q, pair_d;
    logic              pair_err_q, pair_err_d;
    logic              pair_valid_q, pair_valid_d;
    logic              mismatch;
    logic              pair_acc;
    logic              err_inc;

    // Even byte must have LSB 0, odd byte LSB 1.
    assign mismatch = e_bad_q | ~src_d_in[0];
    assign pair_acc = (state_q == S_HOLD) && pair_valid_q && pair_ready;
    assign err_inc  = (state_q == S_CAP_O) && mismatch;

    // Gated by reset so no read escapes while upstream is also held in reset.
    assign src_r_en = reset && src_avail && ((state_q == S_REQ_E) || (state_q == S_REQ_O));

    always_comb begin
        state_d      = state_q;
        even_d       = even_q;
        e_bad_d      = e_bad_q;
        pair_d       = pair_q;
        pair_err_d   = pair_err_q;
        pair_valid_d = pair_valid_q;
        unique case (state_q)
            S_REQ_E: begin
                if (src_avail) state_d = S_CAP_E;
            end
            S_CAP_E: begin
                even_d  = src_d_in;
                e_bad_d = src_d_in[0];
                state_d = S_REQ_O;
            end
            S_REQ_O: begin
                if (src_avail) state_d = S_CAP_O;
            end
            S_CAP_O: begin
`ifdef EO_PAIR_DROP_ERR_EN
                if (mismatch) begin
                    state_d = S_REQ_E;
                end else begin
                    pair_d       = '{odd: src_d_in, even: even_q};
                    pair_err_d   = 1'b0;
                    pair_valid_d = 1'b1;
                    state_d      = S_HOLD;
                end
`else
                pair_d       = '{odd: src_d_in, even: even_q};
                pair_err_d   = mismatch;
                pair_valid_d = 1'b1;
                state_d      = S_HOLD;
`endif
            end
            S_HOLD: begin
                if (pair_acc) begin
                    pair_valid_d = 1'b0;
                    state_d      = S_REQ_E;
                end
            end
            default: state_d = S_REQ_E;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_REQ_E;
            even_q       <= '0;
            e_bad_q      <= 1'b0;
            pair_q       <= '0;
            pair_err_q   <= 1'b0;
            pair_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            even_q       <= even_d;
            e_bad_q      <= e_bad_d;
            pair_q       <= pair_d;
            pair_err_q   <= pair_err_d;
            pair_valid_q <= pair_valid_d;
        end
    end

    assign pair_valid = pair_valid_q;
    assign pair_data  = pair_q;
    assign pair_err   = pair_err_q;

    eo_sat_counter #(
        .W(CNT_W)
    ) u_pair_cnt (
        .clk  (clk),
        .reset(reset),
        .en   (pair_acc),
        .sat  (1'b0),
        .count(pair_count)
    );

    eo_sat_counter #(
        .W(ERR_W)
    ) u_err_cnt (
        .clk  (clk),
        .reset(reset),
        .en   (err_inc),
        .sat  (1'b1),
        .count(err_count)
    );

endmodule

// File: tb/tb_eo_pair_packer.sv
// Self-checking bench for eo_pair_packer: behavioural upstream byte source,
// scoreboard of expected pairs popped on each downstream handshake.
module tb_eo_pair_packer;
    import eo_pkg::*;

    localparam int unsigned CNT_W = 4;
    localparam int unsigned ERR_W = 8;
`ifdef EO_PAIR_DROP_ERR_EN
    localparam bit DROP = 1'b1;
`else
    localparam bit DROP = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             src_avail = 1'b0;
    logic             src_r_en;
    logic [7:0]       src_d_in;
    logic             pair_valid;
    logic             pair_ready = 1'b0;
    logic [15:0]      pair_data;
    logic             pair_err;
    logic [CNT_W-1:0] pair_count;
    logic [ERR_W-1:0] err_count;

    eo_pair_packer #(
        .CNT_W(CNT_W),
        .ERR_W(ERR_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .src_avail (src_avail),
        .src_r_en  (src_r_en),
        .src_d_in  (src_d_in),
        .pair_valid(pair_valid),
        .pair_ready(pair_ready),
        .pair_data (pair_data),
        .pair_err  (pair_err),
        .pair_count(pair_count),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  even;
        logic [7:0]  odd;
        logic [15:0] data;
        logic        err;
    } vec_t;

    typedef struct {
        logic [15:0] data;
        logic        err;
    } exp_t;

    logic [7:0] up_q[$];
    exp_t       exp_q[$];
    logic       avail_en = 1'b0;
    int         n_pass = 0;
    int         n_total = 0;
    int         exp_pc = 0;
    int         exp_ec = 0;
    vec_t       vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Upstream stage: registered byte appears the cycle after a read.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            src_d_in <= 8'h00;
        end else if (src_r_en && (up_q.size() != 0)) begin
            src_d_in <= up_q.pop_front();
        end
    end

    always @(negedge clk) begin
        src_avail = avail_en && (up_q.size() != 0);
    end

    // Scoreboard: a transfer happens at the posedge after valid&ready is seen.
    always @(negedge clk) begin
        exp_t e;
        if (reset && pair_valid && pair_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pair", {16'h0, pair_data}, 32'hdead);
            end else begin
                e = exp_q.pop_front();
                check("pair_data", {16'h0, pair_data}, {16'h0, e.data});
                check("pair_err", {31'h0, pair_err}, {31'h0, e.err});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_pair(input logic [15:0] data, input logic err);
        exp_t e;
        if (err) exp_ec = (exp_ec == 255) ? 255 : exp_ec + 1;
        if (!(DROP && err)) begin
            e.data = data;
            e.err  = err;
            exp_q.push_back(e);
            exp_pc = (exp_pc + 1) % (1 << CNT_W);
        end
    endtask

    task automatic send(input logic [7:0] ev, input logic [7:0] od, input logic [15:0] data,
                        input logic err);
        up_q.push_back(ev);
        up_q.push_back(od);
        expect_pair(data, err);
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (up_q.size() == 0 && exp_q.size() == 0 && !pair_valid && dut.state_q == S_REQ_E)
                return;
        end
        check("drain_timeout", 32'd1, 32'd0);
    endtask

    task automatic do_reset();
        tick();
        reset = 1'b0;
        up_q.delete();
        exp_q.delete();
        exp_pc = 0;
        exp_ec = 0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    initial begin
        int ren_cnt;
        int chg_cnt;
        bit seen;

        vecs[0] = '{even: 8'h02, odd: 8'h05, data: 16'h0502, err: 1'b0};
        vecs[1] = '{even: 8'h04, odd: 8'h81, data: 16'h8104, err: 1'b0};
        vecs[2] = '{even: 8'h03, odd: 8'h07, data: 16'h0703, err: 1'b1};
        vecs[3] = '{even: 8'hfe, odd: 8'hfe, data: 16'hfefe, err: 1'b1};
        vecs[4] = '{even: 8'h00, odd: 8'hff, data: 16'hff00, err: 1'b0};

        // Reset state with src_avail high.
        avail_en   = 1'b1;
        pair_ready = 1'b1;
        send(8'h02, 8'h05, 16'h0502, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check("rst_pair_valid", {31'h0, pair_valid}, 32'd0);
        check("rst_pair_err", {31'h0, pair_err}, 32'd0);
        check("rst_pair_data", {16'h0, pair_data}, 32'h0);
        check("rst_pair_count", {28'h0, pair_count}, 32'd0);
        check("rst_err_count", {24'h0, err_count}, 32'd0);
        check("rst_src_r_en", {31'h0, src_r_en}, 32'd0);
        tick();
        reset = 1'b1;
        @(negedge clk);
        check("first_read", {31'h0, src_r_en}, 32'd1);
        wait_drain(100);
        check("count_after_first", {28'h0, pair_count}, 32'd1);

        // Backpressure: pair held stable, no reads while held.
        tick();
        pair_ready = 1'b0;
        send(8'h02, 8'h05, 16'h0502, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (pair_valid) seen = 1'b1;
        end
        check("bp_valid_seen", {31'h0, seen}, 32'd1);
        send(8'h04, 8'h81, 16'h8104, 1'b0);
        ren_cnt = 0;
        chg_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (pair_data !== 16'h0502 || pair_err !== 1'b0 || pair_valid !== 1'b1) chg_cnt++;
            if (src_r_en) ren_cnt++;
        end
        check("bp_stable", chg_cnt, 0);
        check("bp_no_read", ren_cnt, 0);
        tick();
        pair_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("read_after_accept", {31'h0, src_r_en}, 32'd1);
        wait_drain(100);
        check("count_after_bp", {28'h0, pair_count}, 32'd3);

        // Bubble while waiting for the odd byte.
        tick();
        up_q.push_back(8'h02);
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (up_q.size() == 0 && dut.state_q == S_REQ_O) seen = 1'b1;
        end
        check("bubble_reached", {31'h0, seen}, 32'd1);
        ren_cnt = 0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            if (src_r_en) ren_cnt++;
        end
        check("bubble_no_read", ren_cnt, 0);
        tick();
        up_q.push_back(8'h11);
        expect_pair(16'h1102, 1'b0);
        wait_drain(100);

        // Single class mismatch from a clean reset.
        do_reset();
        send(8'h03, 8'h07, 16'h0703, 1'b1);
        wait_drain(100);
        check("mm_err_count", {24'h0, err_count}, 32'd1);
        check("mm_pair_count", {28'h0, pair_count}, DROP ? 32'd0 : 32'd1);

        // Table of pairs, one at a time.
        for (int i = 0; i < 5; i++) begin
            send(vecs[i].even, vecs[i].odd, vecs[i].data, vecs[i].err);
            wait_drain(100);
            check("tbl_pair_count", {28'h0, pair_count}, exp_pc);
            check("tbl_err_count", {24'h0, err_count}, exp_ec);
        end

        // Async reset while in S_CAP_O aborts the pair.
        tick();
        send(8'h02, 8'h05, 16'h0502, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (dut.state_q == S_CAP_O) seen = 1'b1;
        end
        check("cap_o_reached", {31'h0, seen}, 32'd1);
        reset = 1'b0;
        up_q.delete();
        exp_q.delete();
        exp_pc = 0;
        exp_ec = 0;
        #1;
        check("abort_state", {29'h0, dut.state_q}, {29'h0, S_REQ_E});
        tick();
        check("abort_valid", {31'h0, pair_valid}, 32'd0);
        reset = 1'b1;
        send(8'h04, 8'h09, 16'h0904, 1'b0);
        wait_drain(100);
        check("abort_realign_count", {28'h0, pair_count}, 32'd1);

        // pair_count wraps: 17 pairs on a 4-bit counter.
        do_reset();
        for (int i = 0; i < 17; i++) begin
            logic [7:0] ev;
            logic [7:0] od;
            ev = 8'(2 * i);
            od = 8'(2 * i + 1);
            send(ev, od, {od, ev}, 1'b0);
        end
        wait_drain(500);
        check("wrap_pair_count", {28'h0, pair_count}, 32'd1);

        // err_count saturates after 300 mismatches.
        do_reset();
        for (int i = 0; i < 300; i++) begin
            send(8'h01, 8'h00, 16'h0001, 1'b1);
        end
        wait_drain(3000);
        check("sat_err_count", {24'h0, err_count}, 32'd255);
        check("sat_pair_count", {28'h0, pair_count}, exp_pc);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Absolute time limit so the bench can never hang.
    initial begin
        #2000000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule
